// File: rtl/rf_rdport_arb_pkg.sv
// Shared widths, constants and FSM encoding for the register-file read-port arbiter.
package rf_rdport_arb_pkg;

  localparam int unsigned RADDR_WIDTH = 5;
  localparam int unsigned RDATA_WIDTH = 32;

  localparam logic [RADDR_WIDTH-1:0] ZERO_REG     = '0;
  localparam logic [RDATA_WIDTH-1:0] ZERO         = '0;
  localparam logic                   READ_ENABLE  = 1'b1;
  localparam logic                   READ_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    RF_ARB_IDLE = 2'b00,
    RF_ARB_RD1  = 2'b01,
    RF_ARB_RD2  = 2'b10,
    RF_ARB_DBG  = 2'b11
  } rf_arb_state_e;

endpackage

// File: rtl/rf_arb_age_cnt.sv
// Saturating age counter: how long a pending debug read has been losing arbitration.
module rf_arb_age_cnt #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int unsigned W = $clog2(MAX_WAIT + 1);

  logic [W-1:0] age;

  assign sat = (age == W'(MAX_WAIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age <= '0;
    end else if (clr) begin
      age <= '0;
    end else if (inc && !sat) begin
      age <= age + W'(1);
    end
  end

endmodule

// File: rtl/rf_rdport_arb.sv
// Shares the single regfile read port between decode (rs1/rs2, serialised) and debug reads.
module rf_rdport_arb
  import rf_rdport_arb_pkg::*;
#(
  parameter int unsigned DBG_MAX_WAIT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_req_i,
  input  logic                   id_reg1_re_i,
  input  logic [RADDR_WIDTH-1:0] id_reg1_raddr_i,
  input  logic                   id_reg2_re_i,
  input  logic [RADDR_WIDTH-1:0] id_reg2_raddr_i,
  output logic                   id_ready_o,
  output logic                   id_rvalid_o,
  output logic [RDATA_WIDTH-1:0] id_reg1_rdata_o,
  output logic [RDATA_WIDTH-1:0] id_reg2_rdata_o,
  input  logic                   flush_i,
  input  logic                   dbg_req_i,
  input  logic [RADDR_WIDTH-1:0] dbg_raddr_i,
  output logic                   dbg_gnt_o,
  output logic                   dbg_rvalid_o,
  output logic [RDATA_WIDTH-1:0] dbg_rdata_o,
  output logic                   rf_re_o,
  output logic [RADDR_WIDTH-1:0] rf_raddr_o,
  input  logic [RDATA_WIDTH-1:0] rf_rdata_i
);

  rf_arb_state_e          state;
  logic [RADDR_WIDTH-1:0] reg1_raddr_q;
  logic [RADDR_WIDTH-1:0] reg2_raddr_q;
  logic                   reg2_need_q;
  logic [RADDR_WIDTH-1:0] dbg_raddr_q;
  logic [RDATA_WIDTH-1:0] op1_q;

  logic age_sat;
  logic is_idle;
  logic dbg_win;
  logic id_accept;
  logic reg1_need;
  logic reg2_need;

  assign is_idle   = (state == RF_ARB_IDLE);
  assign dbg_win   = is_idle & dbg_req_i & (~id_req_i | age_sat);
  // Handshakes are gated by rst_n so that every output reads 0 while reset is held.
  assign id_ready_o = rst_n & is_idle & ~dbg_win & ~flush_i;
  assign dbg_gnt_o  = rst_n & dbg_win;
  assign id_accept  = id_req_i & id_ready_o;
  assign reg1_need  = id_reg1_re_i & (id_reg1_raddr_i != ZERO_REG);
  assign reg2_need  = id_reg2_re_i & (id_reg2_raddr_i != ZERO_REG);

  rf_arb_age_cnt #(
    .MAX_WAIT (DBG_MAX_WAIT)
  ) u_age (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (dbg_req_i & ~dbg_gnt_o),
    .clr   (dbg_gnt_o),
    .sat   (age_sat)
  );

  always_comb begin
    rf_re_o    = READ_DISABLE;
    rf_raddr_o = ZERO_REG;
    unique case (state)
      RF_ARB_RD1: begin rf_re_o = READ_ENABLE; rf_raddr_o = reg1_raddr_q; end
      RF_ARB_RD2: begin rf_re_o = READ_ENABLE; rf_raddr_o = reg2_raddr_q; end
      RF_ARB_DBG: begin rf_re_o = READ_ENABLE; rf_raddr_o = dbg_raddr_q;  end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= RF_ARB_IDLE;
      reg1_raddr_q    <= ZERO_REG;
      reg2_raddr_q    <= ZERO_REG;
      reg2_need_q     <= 1'b0;
      dbg_raddr_q     <= ZERO_REG;
      op1_q           <= ZERO;
      id_rvalid_o     <= 1'b0;
      id_reg1_rdata_o <= ZERO;
      id_reg2_rdata_o <= ZERO;
      dbg_rvalid_o    <= 1'b0;
      dbg_rdata_o     <= ZERO;
    end else begin
      id_rvalid_o  <= 1'b0;
      dbg_rvalid_o <= 1'b0;
      unique case (state)
        RF_ARB_IDLE: begin
          if (dbg_win) begin
            dbg_raddr_q <= dbg_raddr_i;
            state       <= RF_ARB_DBG;
          end else if (id_accept) begin
            reg1_raddr_q <= id_reg1_raddr_i;
            reg2_raddr_q <= id_reg2_raddr_i;
            reg2_need_q  <= reg2_need;
            // op1 defaults to ZERO so an rs2-only request can go straight to RD2.
            op1_q        <= ZERO;
            if (reg1_need) begin
              state <= RF_ARB_RD1;
            end else if (reg2_need) begin
              state <= RF_ARB_RD2;
            end else begin
              id_rvalid_o     <= 1'b1;
              id_reg1_rdata_o <= ZERO;
              id_reg2_rdata_o <= ZERO;
            end
          end
        end
        RF_ARB_RD1: begin
          if (flush_i) begin
            state <= RF_ARB_IDLE;
          end else if (reg2_need_q) begin
            op1_q <= rf_rdata_i;
            state <= RF_ARB_RD2;
          end else begin
            id_rvalid_o     <= 1'b1;
            id_reg1_rdata_o <= rf_rdata_i;
            id_reg2_rdata_o <= ZERO;
            state           <= RF_ARB_IDLE;
          end
        end
        RF_ARB_RD2: begin
          if (!flush_i) begin
            id_rvalid_o     <= 1'b1;
            id_reg1_rdata_o <= op1_q;
            id_reg2_rdata_o <= rf_rdata_i;
          end
          state <= RF_ARB_IDLE;
        end
        RF_ARB_DBG: begin
          dbg_rvalid_o <= 1'b1;
          dbg_rdata_o  <= (dbg_raddr_q == ZERO_REG) ? ZERO : rf_rdata_i;
          state        <= RF_ARB_IDLE;
        end
        default: state <= RF_ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_rdport_arb.sv
// Directed bench for rf_rdport_arb with a combinational regfile model.
module tb_rf_rdport_arb;
  import rf_rdport_arb_pkg::*;

  logic                   clk;
  logic                   rst_n;
  logic                   id_req;
  logic                   id_reg1_re;
  logic [RADDR_WIDTH-1:0] id_reg1_raddr;
  logic                   id_reg2_re;
  logic [RADDR_WIDTH-1:0] id_reg2_raddr;
  logic                   id_ready;
  logic                   id_rvalid;
  logic [RDATA_WIDTH-1:0] id_reg1_rdata;
  logic [RDATA_WIDTH-1:0] id_reg2_rdata;
  logic                   flush;
  logic                   dbg_req;
  logic [RADDR_WIDTH-1:0] dbg_raddr;
  logic                   dbg_gnt;
  logic                   dbg_rvalid;
  logic [RDATA_WIDTH-1:0] dbg_rdata;
  logic                   rf_re;
  logic [RADDR_WIDTH-1:0] rf_raddr;
  logic [RDATA_WIDTH-1:0] rf_rdata;

  logic [RDATA_WIDTH-1:0] mem [32];
  int n_tests;
  int n_fail;
  int waited;

  rf_rdport_arb #(
    .DBG_MAX_WAIT (8)
  ) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_req_i        (id_req),
    .id_reg1_re_i    (id_reg1_re),
    .id_reg1_raddr_i (id_reg1_raddr),
    .id_reg2_re_i    (id_reg2_re),
    .id_reg2_raddr_i (id_reg2_raddr),
    .id_ready_o      (id_ready),
    .id_rvalid_o     (id_rvalid),
    .id_reg1_rdata_o (id_reg1_rdata),
    .id_reg2_rdata_o (id_reg2_rdata),
    .flush_i         (flush),
    .dbg_req_i       (dbg_req),
    .dbg_raddr_i     (dbg_raddr),
    .dbg_gnt_o       (dbg_gnt),
    .dbg_rvalid_o    (dbg_rvalid),
    .dbg_rdata_o     (dbg_rdata),
    .rf_re_o         (rf_re),
    .rf_raddr_o      (rf_raddr),
    .rf_rdata_i      (rf_rdata)
  );

  assign rf_rdata = mem[rf_raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic re1, input logic [4:0] a1, input logic re2, input logic [4:0] a2);
    id_reg1_re    = re1;
    id_reg1_raddr = a1;
    id_reg2_re    = re2;
    id_reg2_raddr = a2;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'hA000_0000 | i;
    mem[0] = 32'hDEAD_BEEF;
    mem[5] = 32'h11;
    mem[6] = 32'h22;

    rst_n = 1'b0; id_req = 1'b0; flush = 1'b0; dbg_req = 1'b0; dbg_raddr = '0;
    set_id(1'b0, 5'd0, 1'b0, 5'd0);
    #3;
    check("rst_ready", id_ready, 0);
    check("rst_rvalid", id_rvalid, 0);
    check("rst_rf_re", rf_re, 0);
    check("rst_d1", id_reg1_rdata, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    // 1: two reads, latency 3
    id_req = 1'b1; set_id(1'b1, 5'd5, 1'b1, 5'd6); #1;
    check("t1_ready", id_ready, 1);
    check("t1_rf_re_idle", rf_re, 0);
    step(); id_req = 1'b0; #1;
    check("t1_rf_re_rd1", rf_re, 1);
    check("t1_raddr_rd1", rf_raddr, 5);
    check("t1_rvalid_early", id_rvalid, 0);
    step();
    check("t1_raddr_rd2", rf_raddr, 6);
    step();
    check("t1_rvalid", id_rvalid, 1);
    check("t1_d1", id_reg1_rdata, 32'h11);
    check("t1_d2", id_reg2_rdata, 32'h22);
    step();
    check("t1_rvalid_pulse", id_rvalid, 0);
    check("t1_d1_hold", id_reg1_rdata, 32'h11);

    // 2: x0 read only -> no port use, latency 1
    id_req = 1'b1; set_id(1'b1, 5'd0, 1'b0, 5'd6); #1;
    check("t2_ready", id_ready, 1);
    check("t2_rf_re", rf_re, 0);
    step(); id_req = 1'b0; #1;
    check("t2_rvalid", id_rvalid, 1);
    check("t2_d1", id_reg1_rdata, 0);
    check("t2_d2", id_reg2_rdata, 0);
    check("t2_rf_re_after", rf_re, 0);

    // 6: back-to-back two-read requests
    step();
    id_req = 1'b1; set_id(1'b1, 5'd5, 1'b1, 5'd6); #1;
    check("t6_ready0", id_ready, 1);
    step(); set_id(1'b1, 5'd7, 1'b1, 5'd8); #1;
    check("t6_ready1", id_ready, 0);
    step();
    check("t6_ready2", id_ready, 0);
    check("t6_rvalid2", id_rvalid, 0);
    step();
    check("t6_rvalid3", id_rvalid, 1);
    check("t6_ready3", id_ready, 1);
    check("t6_d1a", id_reg1_rdata, 32'h11);
    check("t6_d2a", id_reg2_rdata, 32'h22);
    step(); id_req = 1'b0; #1;
    check("t6_rvalid4", id_rvalid, 0);
    check("t6_raddr4", rf_raddr, 7);
    step();
    check("t6_raddr5", rf_raddr, 8);
    step();
    check("t6_rvalid6", id_rvalid, 1);
    check("t6_d1b", id_reg1_rdata, 32'hA000_0007);
    check("t6_d2b", id_reg2_rdata, 32'hA000_0008);

    // 4: flush during RD2
    step();
    id_req = 1'b1; set_id(1'b1, 5'd5, 1'b1, 5'd6); #1;
    check("t4_ready", id_ready, 1);
    step(); id_req = 1'b0; #1;
    check("t4_raddr_rd1", rf_raddr, 5);
    step(); flush = 1'b1; #1;
    check("t4_raddr_rd2", rf_raddr, 6);
    step(); id_req = 1'b1; set_id(1'b1, 5'd6, 1'b0, 5'd0); #1;
    check("t4_no_rvalid", id_rvalid, 0);
    check("t4_d1_hold", id_reg1_rdata, 32'hA000_0007);
    check("t4_d2_hold", id_reg2_rdata, 32'hA000_0008);
    check("t4_flush_blocks", id_ready, 0);
    flush = 1'b0; #1;
    check("t4_ready_after", id_ready, 1);
    step(); id_req = 1'b0; #1;
    check("t4_raddr_next", rf_raddr, 6);
    check("t4_rvalid_early", id_rvalid, 0);
    step();
    check("t4_rvalid", id_rvalid, 1);
    check("t4_d1", id_reg1_rdata, 32'h22);
    check("t4_d2", id_reg2_rdata, 0);

    // debug grant while flush blocks decode
    step(); flush = 1'b1; dbg_req = 1'b1; dbg_raddr = 5'd9; #1;
    check("dbg_gnt_flush", dbg_gnt, 1);
    check("dbg_ready_flush", id_ready, 0);
    step(); dbg_req = 1'b0; #1;
    check("dbg_rf_re", rf_re, 1);
    check("dbg_raddr", rf_raddr, 9);
    check("dbg_rvalid_early", dbg_rvalid, 0);
    step(); flush = 1'b0; #1;
    check("dbg_rvalid", dbg_rvalid, 1);
    check("dbg_rdata", dbg_rdata, 32'hA000_0009);
    step();
    check("dbg_rvalid_pulse", dbg_rvalid, 0);

    // debug to x0 uses the port, returns zero
    dbg_req = 1'b1; dbg_raddr = 5'd0; #1;
    check("dbg0_gnt", dbg_gnt, 1);
    step(); dbg_req = 1'b0; #1;
    check("dbg0_rf_re", rf_re, 1);
    check("dbg0_raddr", rf_raddr, 0);
    step();
    check("dbg0_rvalid", dbg_rvalid, 1);
    check("dbg0_rdata", dbg_rdata, 0);

    // 5: async reset mid-RD1
    step();
    id_req = 1'b1; set_id(1'b1, 5'd5, 1'b1, 5'd6); #1;
    step(); id_req = 1'b0; #1;
    check("t5_rd1", rf_re, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rf_re", rf_re, 0);
    check("t5_raddr", rf_raddr, 0);
    check("t5_d1", id_reg1_rdata, 0);
    check("t5_ready", id_ready, 0);
    #10 rst_n = 1'b1;
    step();
    check("t5_idle_rf_re", rf_re, 0);
    check("t5_idle_ready", id_ready, 1);
    id_req = 1'b1; set_id(1'b1, 5'd5, 1'b1, 5'd6);
    step(); id_req = 1'b0; #1;
    check("t5_again_raddr", rf_raddr, 5);
    step(); step();
    check("t5_again_rvalid", id_rvalid, 1);
    check("t5_again_d1", id_reg1_rdata, 32'h11);

    // 3: starvation bound with decode held continuously
    step();
    id_req = 1'b1; set_id(1'b0, 5'd0, 1'b0, 5'd0); dbg_req = 1'b1; dbg_raddr = 5'd9; #1;
    check("t3_decode_wins", id_ready, 1);
    check("t3_no_gnt", dbg_gnt, 0);
    for (int pass = 0; pass < 2; pass++) begin
      waited = -1;
      for (int k = 0; k < 16; k++) begin
        if (dbg_gnt) begin
          waited = k;
          break;
        end
        step();
      end
      check("t3_wait", 32'(waited), 8);
      check("t3_ready_at_gnt", id_ready, 0);
      step(); dbg_req = 1'b0; #1;
      check("t3_dbg_raddr", rf_raddr, 9);
      check("t3_dbg_ready", id_ready, 0);
      step();
      check("t3_dbg_rvalid", dbg_rvalid, 1);
      check("t3_dbg_rdata", dbg_rdata, 32'hA000_0009);
      dbg_req = 1'b1; #1;
    end
    dbg_req = 1'b0; id_req = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
